// File: rtl/reservation_station_if.sv
// Dispatch, operand, common-data-bus and issue signals of one reservation station.
// The station itself takes the slave side; whoever feeds it takes the master side.
interface reservation_station_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;

  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [3:0]       dispatch_station;
  logic [5:0]       dispatch_alu_fn;
  logic [15:0]      dispatch_immediate;
  logic [TAG_W-1:0] dispatch_dest_tag;

  logic             src1_ready;
  logic             src2_ready;
  logic [31:0]      src1_value;
  logic [31:0]      src2_value;
  logic [TAG_W-1:0] src1_tag;
  logic [TAG_W-1:0] src2_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             issue_valid;
  logic             issue_ready;
  logic [5:0]       issue_alu_fn;
  logic [31:0]      issue_op1;
  logic [31:0]      issue_op2;
  logic [15:0]      issue_immediate;
  logic [TAG_W-1:0] issue_dest_tag;

  logic [CNT_W-1:0] occupancy;

  modport master (
    output flush,
    output dispatch_valid, dispatch_station, dispatch_alu_fn, dispatch_immediate, dispatch_dest_tag,
    output src1_ready, src2_ready, src1_value, src2_value, src1_tag, src2_tag,
    output cdb_valid, cdb_tag, cdb_value,
    output issue_ready,
    input  dispatch_ready,
    input  issue_valid, issue_alu_fn, issue_op1, issue_op2, issue_immediate, issue_dest_tag,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  dispatch_valid, dispatch_station, dispatch_alu_fn, dispatch_immediate, dispatch_dest_tag,
    input  src1_ready, src2_ready, src1_value, src2_value, src1_tag, src2_tag,
    input  cdb_valid, cdb_tag, cdb_value,
    input  issue_ready,
    output dispatch_ready,
    output issue_valid, issue_alu_fn, issue_op1, issue_op2, issue_immediate, issue_dest_tag,
    output occupancy
  );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo-style reservation station: holds dispatched ops until both operands are
// known (directly or via CDB snooping) and issues the lowest-index ready entry.
module reservation_station #(
  parameter int STATION_ID = 1,
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  reservation_station_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [3:0] STATION_CODE = 4'(STATION_ID);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] src1_rdy_reg;
  logic [DEPTH-1:0] src2_rdy_reg;
  logic [5:0]       alu_fn_reg   [DEPTH];
  logic [15:0]      imm_reg      [DEPTH];
  logic [TAG_W-1:0] dest_tag_reg [DEPTH];
  logic [TAG_W-1:0] src1_tag_reg [DEPTH];
  logic [TAG_W-1:0] src2_tag_reg [DEPTH];
  logic [31:0]      src1_val_reg [DEPTH];
  logic [31:0]      src2_val_reg [DEPTH];

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] wake1;
  logic [DEPTH-1:0] wake2;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] issue_idx;
  logic [CNT_W-1:0] occ_count;
  logic             has_free;
  logic             issue_any;
  logic             dispatch_fire;
  logic             issue_fire;
  logic             in1_rdy;
  logic             in2_rdy;
  logic [31:0]      in1_val;
  logic [31:0]      in2_val;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign eligible[gi] = valid_reg[gi] & src1_rdy_reg[gi] & src2_rdy_reg[gi];
      assign wake1[gi]    = rs.cdb_valid && !src1_rdy_reg[gi] && (src1_tag_reg[gi] == rs.cdb_tag);
      assign wake2[gi]    = rs.cdb_valid && !src2_rdy_reg[gi] && (src2_tag_reg[gi] == rs.cdb_tag);
    end
  endgenerate

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    occ_count = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = IDX_W'(i);
      if (eligible[i])   issue_idx = IDX_W'(i);
      occ_count = occ_count + CNT_W'(valid_reg[i]);
    end
  end

  assign has_free      = ~&valid_reg;
  assign issue_any     = |eligible;
  assign dispatch_fire = rs.dispatch_valid && has_free && !rs.flush &&
                         (rs.dispatch_station == STATION_CODE);
  assign issue_fire    = issue_any && rs.issue_ready;

  // An operand broadcast in the dispatch cycle is caught on the way in.
  assign in1_rdy = rs.src1_ready || (rs.cdb_valid && (rs.cdb_tag == rs.src1_tag));
  assign in2_rdy = rs.src2_ready || (rs.cdb_valid && (rs.cdb_tag == rs.src2_tag));
  assign in1_val = rs.src1_ready ? rs.src1_value : rs.cdb_value;
  assign in2_val = rs.src2_ready ? rs.src2_value : rs.cdb_value;

  // free_idx is always an invalid slot, so it can never collide with issue_idx.
  always_comb begin
    valid_next = valid_reg;
    if (issue_fire)    valid_next[issue_idx] = 1'b0;
    if (dispatch_fire) valid_next[free_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (rs.flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Payload needs no reset: nothing here is observed unless the valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wake1[i]) begin
        src1_rdy_reg[i] <= 1'b1;
        src1_val_reg[i] <= rs.cdb_value;
      end
      if (wake2[i]) begin
        src2_rdy_reg[i] <= 1'b1;
        src2_val_reg[i] <= rs.cdb_value;
      end
    end
    if (dispatch_fire) begin
      alu_fn_reg[free_idx]   <= rs.dispatch_alu_fn;
      imm_reg[free_idx]      <= rs.dispatch_immediate;
      dest_tag_reg[free_idx] <= rs.dispatch_dest_tag;
      src1_tag_reg[free_idx] <= rs.src1_tag;
      src2_tag_reg[free_idx] <= rs.src2_tag;
      src1_rdy_reg[free_idx] <= in1_rdy;
      src2_rdy_reg[free_idx] <= in2_rdy;
      src1_val_reg[free_idx] <= in1_val;
      src2_val_reg[free_idx] <= in2_val;
    end
  end

  assign rs.dispatch_ready  = has_free;
  assign rs.issue_valid     = issue_any;
  assign rs.issue_alu_fn    = issue_any ? alu_fn_reg[issue_idx]   : '0;
  assign rs.issue_op1       = issue_any ? src1_val_reg[issue_idx] : '0;
  assign rs.issue_op2       = issue_any ? src2_val_reg[issue_idx] : '0;
  assign rs.issue_immediate = issue_any ? imm_reg[issue_idx]      : '0;
  assign rs.issue_dest_tag  = issue_any ? dest_tag_reg[issue_idx] : '0;
  assign rs.occupancy       = occ_count;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table, hand-written full/flush/reset
// sequences, and a randomized run against a slot-array reference model.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reservation_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  reservation_station #(.STATION_ID(1), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs    (bus)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    bit        v;
    bit [5:0]  fn;
    bit [15:0] imm;
    bit [3:0]  dest;
    bit        r1;
    bit        r2;
    bit [31:0] o1;
    bit [31:0] o2;
    bit [3:0]  t1;
    bit [3:0]  t2;
  } ent_t;

  ent_t m [DEPTH];

  function automatic int m_oldest_ready();
    for (int i = 0; i < DEPTH; i++)
      if (m[i].v && m[i].r1 && m[i].r2) return i;
    return -1;
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < DEPTH; i++)
      if (!m[i].v) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].v) c++;
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_clock();
    ent_t n [DEPTH];
    int ii;
    int fi;
    if (!rst_n || bus.flush) begin
      m_clear();
      return;
    end
    ii = bus.issue_ready ? m_oldest_ready() : -1;
    fi = (bus.dispatch_valid && bus.dispatch_station == 4'd1) ? m_first_free() : -1;
    n = m;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && bus.cdb_valid && !m[i].r1 && m[i].t1 == bus.cdb_tag) begin
        n[i].r1 = 1'b1; n[i].o1 = bus.cdb_value;
      end
      if (m[i].v && bus.cdb_valid && !m[i].r2 && m[i].t2 == bus.cdb_tag) begin
        n[i].r2 = 1'b1; n[i].o2 = bus.cdb_value;
      end
    end
    if (ii >= 0) n[ii].v = 1'b0;
    if (fi >= 0) begin
      n[fi].v    = 1'b1;
      n[fi].fn   = bus.dispatch_alu_fn;
      n[fi].imm  = bus.dispatch_immediate;
      n[fi].dest = bus.dispatch_dest_tag;
      n[fi].t1   = bus.src1_tag;
      n[fi].t2   = bus.src2_tag;
      n[fi].r1   = bus.src1_ready || (bus.cdb_valid && bus.cdb_tag == bus.src1_tag);
      n[fi].r2   = bus.src2_ready || (bus.cdb_valid && bus.cdb_tag == bus.src2_tag);
      n[fi].o1   = bus.src1_ready ? bus.src1_value : bus.cdb_value;
      n[fi].o2   = bus.src2_ready ? bus.src2_value : bus.cdb_value;
    end
    m = n;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int k;
    k = m_oldest_ready();
    chk({tag, "_issue_valid"}, 32'(bus.issue_valid), 32'(k >= 0));
    chk({tag, "_dispatch_ready"}, 32'(bus.dispatch_ready), 32'(m_first_free() >= 0));
    chk({tag, "_occupancy"}, 32'(bus.occupancy), 32'(m_count()));
    if (k >= 0) begin
      chk({tag, "_op1"}, bus.issue_op1, m[k].o1);
      chk({tag, "_op2"}, bus.issue_op2, m[k].o2);
      chk({tag, "_fn"}, 32'(bus.issue_alu_fn), 32'(m[k].fn));
      chk({tag, "_imm"}, 32'(bus.issue_immediate), 32'(m[k].imm));
      chk({tag, "_dest"}, 32'(bus.issue_dest_tag), 32'(m[k].dest));
    end
  endtask

  task automatic idle();
    bus.flush = 0;             bus.dispatch_valid = 0;     bus.dispatch_station = 4'd1;
    bus.dispatch_alu_fn = '0;  bus.dispatch_immediate = '0; bus.dispatch_dest_tag = '0;
    bus.src1_ready = 0;        bus.src2_ready = 0;
    bus.src1_value = '0;       bus.src2_value = '0;
    bus.src1_tag = '0;         bus.src2_tag = '0;
    bus.cdb_valid = 0;         bus.cdb_tag = '0;            bus.cdb_value = '0;
    bus.issue_ready = 0;
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready_op(input logic [3:0] dest, input logic [31:0] a, input logic [31:0] b);
    bus.dispatch_valid = 1; bus.dispatch_station = 4'd1; bus.dispatch_dest_tag = dest;
    bus.dispatch_alu_fn = 6'(dest); bus.dispatch_immediate = 16'(a);
    bus.src1_ready = 1; bus.src1_value = a; bus.src2_ready = 1; bus.src2_value = b;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dv;  logic [3:0] st;  logic [5:0] fn;  logic [15:0] imm; logic [3:0] dest;
    logic        s1r; logic [31:0] s1v; logic [3:0] s1t;
    logic        s2r; logic [31:0] s2v; logic [3:0] s2t;
    logic        cv;  logic [3:0] ct;  logic [31:0] cval;
    logic        ir;
    logic        e_iv; logic [31:0] e_op1; logic [31:0] e_op2; logic [3:0] e_dest;
    logic        e_dr; logic [2:0] e_occ;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  task automatic apply(input vec_t v);
    bus.flush = 0;
    bus.dispatch_valid = v.dv; bus.dispatch_station = v.st; bus.dispatch_alu_fn = v.fn;
    bus.dispatch_immediate = v.imm; bus.dispatch_dest_tag = v.dest;
    bus.src1_ready = v.s1r; bus.src1_value = v.s1v; bus.src1_tag = v.s1t;
    bus.src2_ready = v.s2r; bus.src2_value = v.s2v; bus.src2_tag = v.s2t;
    bus.cdb_valid = v.cv; bus.cdb_tag = v.ct; bus.cdb_value = v.cval;
    bus.issue_ready = v.ir;
  endtask

  initial begin
    //         dv st fn imm   dest s1r s1v        s1t s2r s2v    s2t cv ct cval       ir  iv op1        op2    dest dr occ
    tbl[0]  = '{1, 1, 0, 0,     3, 1, 5,          0, 1, 7,      0, 0, 0, 0,         1,  1, 5,         7,     3,   1, 1};
    tbl[1]  = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 0};
    tbl[2]  = '{1, 1, 2, 16,    4, 0, 0,          2, 1, 'h11,   0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 1};
    tbl[3]  = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 1, 2, 'h1234,    1,  1, 'h1234,    'h11,  4,   1, 1};
    tbl[4]  = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 0};
    tbl[5]  = '{1, 1, 3, 0,     5, 1, 'h22,       0, 0, 0,      6, 1, 6, 9,         0,  1, 'h22,      9,     5,   1, 1};
    tbl[6]  = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 0};
    tbl[7]  = '{1, 2, 1, 0,     8, 1, 1,          0, 1, 2,      0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 0};
    tbl[8]  = '{1, 1, 4, 0,     6, 0, 0,          7, 1, 'h33,   0, 1, 8, 'h55,      1,  0, 0,         0,     0,   1, 1};
    tbl[9]  = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 1, 7, 'hABCD,    1,  1, 'hABCD,    'h33,  6,   1, 1};
    tbl[10] = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 0};
    tbl[11] = '{1, 1, 5, 0,     1, 1, 'h41,       0, 1, 'h42,   0, 0, 0, 0,         0,  1, 'h41,      'h42,  1,   1, 1};
    tbl[12] = '{1, 1, 5, 0,     2, 1, 'h51,       0, 1, 'h52,   0, 0, 0, 0,         0,  1, 'h41,      'h42,  1,   1, 2};
    tbl[13] = '{1, 1, 5, 0,     7, 1, 'h71,       0, 1, 'h72,   0, 0, 0, 0,         1,  1, 'h51,      'h52,  2,   1, 2};
    tbl[14] = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 0, 0, 0,         1,  1, 'h71,      'h72,  7,   1, 1};
    tbl[15] = '{0, 1, 0, 0,     0, 0, 0,          0, 0, 0,      0, 0, 0, 0,         1,  0, 0,         0,     0,   1, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    m_clear();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("reset_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset_op1", bus.issue_op1, 32'd0);
    chk("reset_dest", 32'(bus.issue_dest_tag), 32'd0);
    rst_n = 1;

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
      cycle();
      $display("vec %0d: issue_valid=%0b dest=%0d op1=0x%0h op2=0x%0h occ=%0d",
               i, bus.issue_valid, bus.issue_dest_tag, bus.issue_op1, bus.issue_op2, bus.occupancy);
      chk($sformatf("vec%0d_issue_valid", i), 32'(bus.issue_valid), 32'(tbl[i].e_iv));
      chk($sformatf("vec%0d_dispatch_ready", i), 32'(bus.dispatch_ready), 32'(tbl[i].e_dr));
      chk($sformatf("vec%0d_occupancy", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d_op1", i), bus.issue_op1, tbl[i].e_op1);
        chk($sformatf("vec%0d_op2", i), bus.issue_op2, tbl[i].e_op2);
        chk($sformatf("vec%0d_dest", i), 32'(bus.issue_dest_tag), 32'(tbl[i].e_dest));
      end
      check_model($sformatf("vec%0d_model", i));
    end

    // Fill all slots with issue stalled, then hold a fifth dispatch until a slot frees.
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      drive_ready_op(4'(10 + k), 32'(100 + k), 32'(200 + k));
      cycle();
      $display("full: dispatched dest=%0d occ=%0d", 10 + k, bus.occupancy);
    end
    chk("full_dispatch_ready", 32'(bus.dispatch_ready), 32'd0);
    chk("full_occupancy", 32'(bus.occupancy), 32'd4);
    drive_ready_op(4'd15, 32'h15, 32'h51);
    repeat (2) cycle();
    $display("full: fifth held occ=%0d ready=%0b", bus.occupancy, bus.dispatch_ready);
    chk("full_hold_occupancy", 32'(bus.occupancy), 32'd4);
    chk("full_hold_dest", 32'(bus.issue_dest_tag), 32'd10);
    bus.issue_ready = 1;
    cycle();
    $display("full: one issued occ=%0d ready=%0b", bus.occupancy, bus.dispatch_ready);
    chk("full_freed_occupancy", 32'(bus.occupancy), 32'd3);
    chk("full_freed_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
    bus.issue_ready = 0;
    cycle();
    $display("full: fifth accepted occ=%0d dest=%0d", bus.occupancy, bus.issue_dest_tag);
    chk("full_accept_occupancy", 32'(bus.occupancy), 32'd4);
    chk("full_accept_dest", 32'(bus.issue_dest_tag), 32'd15);
    idle();
    bus.issue_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      check_model($sformatf("drain%0d", k));
      cycle();
    end
    chk("drain_occupancy", 32'(bus.occupancy), 32'd0);

    // Flush wins over a simultaneous matching dispatch.
    idle();
    for (int k = 0; k < 3; k++) begin
      drive_ready_op(4'(1 + k), 32'(k), 32'(k));
      cycle();
    end
    chk("preflush_occupancy", 32'(bus.occupancy), 32'd3);
    drive_ready_op(4'd9, 32'd9, 32'd9);
    bus.flush = 1;
    cycle();
    $display("flush: occ=%0d issue_valid=%0b", bus.occupancy, bus.issue_valid);
    chk("flush_occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("flush_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);

    // Asynchronous reset in the middle of a cycle drops everything at once.
    idle();
    for (int k = 0; k < 3; k++) begin
      drive_ready_op(4'(4 + k), 32'(k + 7), 32'(k + 8));
      cycle();
    end
    idle();
    #1 rst_n = 0;
    m_clear();
    #1;
    $display("reset: occ=%0d issue_valid=%0b", bus.occupancy, bus.issue_valid);
    chk("midrst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("midrst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("midrst_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
    chk("midrst_op1", bus.issue_op1, 32'd0);
    chk("midrst_op2", bus.issue_op2, 32'd0);
    #1 rst_n = 1;
    drive_ready_op(4'd9, 32'h99, 32'h98);
    cycle();
    chk("postrst_issue_valid", 32'(bus.issue_valid), 32'd1);
    chk("postrst_dest", 32'(bus.issue_dest_tag), 32'd9);
    chk("postrst_occupancy", 32'(bus.occupancy), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.dispatch_valid     = 1'($urandom_range(0, 1));
      bus.dispatch_station   = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd1;
      bus.dispatch_alu_fn    = 6'($urandom);
      bus.dispatch_immediate = 16'($urandom);
      bus.dispatch_dest_tag  = 4'($urandom);
      bus.src1_ready = 1'($urandom_range(0, 1));
      bus.src2_ready = 1'($urandom_range(0, 1));
      bus.src1_value = $urandom;
      bus.src2_value = $urandom;
      bus.src1_tag   = 4'($urandom_range(0, 3));
      bus.src2_tag   = 4'($urandom_range(0, 3));
      bus.cdb_valid  = 1'($urandom_range(0, 1));
      bus.cdb_tag    = 4'($urandom_range(0, 3));
      bus.cdb_value  = $urandom;
      bus.issue_ready = 1'($urandom_range(0, 1));
      bus.flush       = ($urandom_range(0, 49) == 0);
      if (bus.issue_valid && bus.issue_ready && !bus.flush)
        $display("rnd %0d: issue dest=%0d op1=0x%0h op2=0x%0h", c, bus.issue_dest_tag,
                 bus.issue_op1, bus.issue_op2);
      cycle();
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL have parameter STATION_ID, default 1, meaning the rs_station code this instance accepts.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries (power of two, 2..8).
REQ-003 The block SHALL have parameter TAG_W, default 4, meaning the result-tag width.
REQ-004 The block SHALL have the following ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have the following ports: flush  in  1  discard all entries.
REQ-006 The block SHALL have the following ports: dispatch_valid  in  1 / dispatch_ready  out  1  dispatch handshake.
REQ-007 The block SHALL have the following ports: dispatch_station  in  4  target station code; dispatch_alu_fn  in  6  operation; dispatch_immediate  in  16  immediate; dispatch_dest_tag  in  TAG_W  result tag.
REQ-008 The block SHALL have the following ports: src1_ready, src2_ready  in  1  operand already valid; src1_value, src2_value  in  32  operand value; src1_tag, src2_tag  in  TAG_W  producer tag.
REQ-009 The block SHALL have the following ports: cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_value  in  32  common-data-bus result broadcast.
REQ-010 The block SHALL have the following ports: issue_valid  out  1 / issue_ready  in  1  issue handshake.
REQ-011 The block SHALL have the following ports: issue_alu_fn  out  6; issue_op1, issue_op2  out  32; issue_immediate  out  16; issue_dest_tag  out  TAG_W  issued instruction payload.
REQ-012 The block SHALL have the following port: occupancy  out  $clog2(DEPTH)+1  count of valid entries.

Function
REQ-013 The block SHALL hold per entry: valid, alu_fn, immediate, dest_tag, and for each source a ready bit, 32-bit value and tag.
REQ-014 The block SHALL drive dispatch_ready high iff at least one entry is invalid at the start of the cycle, independent of dispatch_station and issue_ready.
REQ-015 Dispatch SHALL fire when dispatch_valid && dispatch_ready && dispatch_station==STATION_ID && !flush, writing the lowest-index invalid entry at the next clock edge.
REQ-016 The block SHALL ignore dispatch_valid with a non-matching dispatch_station, with no state change.
REQ-017 When cdb_valid is high, every valid entry whose source is not ready and whose tag equals cdb_tag SHALL capture cdb_value and set that source ready at the clock edge.
REQ-018 For a source arriving not-ready on a dispatch cycle where cdb_valid && cdb_tag matches its tag, the entry SHALL be written with that source ready and value cdb_value.
REQ-019 An entry SHALL be eligible when valid and both sources are ready in registered state; a source woken this cycle becomes eligible the following cycle.
REQ-020 The block SHALL drive issue_valid combinationally from registered state, high iff any entry is eligible, presenting the lowest-index eligible entry.
REQ-021 Dispatch-to-issue latency SHALL be exactly 1 cycle for an instruction with both sources ready and no older eligible entry.
REQ-022 The issue payload SHALL be held stable while issue_valid && !issue_ready, unless flush or a lower-index entry becomes eligible.
REQ-023 The issuing entry SHALL be invalidated at the edge where issue_valid && issue_ready; the freed slot SHALL NOT be reused by dispatch in the same cycle.
REQ-024 occupancy SHALL increment on dispatch, decrement on issue, hold when both or neither occur, and never exceed DEPTH.
REQ-025 flush SHALL invalidate all entries at the next edge with priority over dispatch, issue and CDB capture; occupancy becomes 0.
REQ-026 When full, dispatch_ready SHALL be low; dispatch_valid held high SHALL be accepted the cycle after a slot frees.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously clear all entry valid bits; issue_valid=0, dispatch_ready=1, occupancy=0, and all issue payload outputs SHALL be 0.
REQ-028 On rst_n low mid-operation, the block SHALL drop all pending entries without issuing them; operation resumes on the first clock edge after rst_n rises.

Verification
REQ-029 Bench scenario: Dispatch fn=0, src1=5, src2=7 both ready, dest=3, issue_ready=1 -> next cycle issue_valid=1, op1=5, op2=7, dest_tag=3; following cycle occupancy=0.
REQ-030 Bench scenario: Dispatch src1 waiting on tag 2, then cdb_valid tag=2 value=0x1234 -> issue_valid rises the cycle after the broadcast with op1=0x1234.
REQ-031 Bench scenario: Dispatch with src2 tag=6 not ready while same-cycle cdb tag=6 value=9 -> issue next cycle with op2=9.
REQ-032 Bench scenario: Fill DEPTH=4 entries with issue_ready=0 -> dispatch_ready=0, occupancy=4; fifth dispatch_valid held until one issue, accepted the next cycle.
REQ-033 Bench scenario: Dispatch with dispatch_station=2 when STATION_ID=1 -> no entry written, occupancy stays 0, issue_valid stays 0.
REQ-034 Bench scenario: With 3 entries valid, assert flush and a matching dispatch together -> occupancy=0 and issue_valid=0 next cycle; rst_n pulse mid-stream -> same result immediately.
